// File: rtl/uart_axil_fifo_if.sv
// AXI4-Lite bus bundle split into read and write channel views.
interface axil_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport rd_slv (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
    modport wr_slv (input awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bresp, bvalid);
    modport rd_mst (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input awready, wready, bresp, bvalid);
endinterface

// File: rtl/uart_axil_fifo.sv
// UART peripheral on AXI4-Lite with RX/TX byte FIFOs, run-time baud divisor,
// optional parity and sticky error flags. Define UART_IRQ_EN to add the irq
// output and the IRQ_EN register at 0x28.
module uart_axil_fifo #(
    parameter int CLKS_PER_BIT_DEFAULT = 72,
    parameter int RX_FIFO_DEPTH        = 16,
    parameter int TX_FIFO_DEPTH        = 16,
    parameter int DATA_BITS            = 8,
    parameter int STOP_BITS            = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
`ifdef UART_IRQ_EN
    output logic             irq,
`endif
    output logic             tx,
    axil_interface_if.rd_slv read_access,
    axil_interface_if.wr_slv write_access
);
    localparam int          RAW       = $clog2(RX_FIFO_DEPTH);
    localparam int          TAW       = $clog2(TX_FIFO_DEPTH);
    localparam logic [7:0]  DMASK     = 8'(9'h1FF >> (9 - DATA_BITS));
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [15:0] DIV_RST   = 16'(CLKS_PER_BIT_DEFAULT);
    localparam logic [RAW:0] RX_FULL  = (RAW+1)'(RX_FIFO_DEPTH);
    localparam logic [TAW:0] TX_FULL  = (TAW+1)'(TX_FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} uart_state_t;

    logic [15:0] ctrl_div;
    logic        ctrl_par_en, ctrl_par_odd, ctrl_rx_en, ctrl_tx_en;
    logic [3:0]  err, err_set, err_clr;
    logic        rvalid, bvalid, ar_hs, aw_hs;
    logic [63:0] rdata, rd_word;
    logic [2:0]  ar_sel, aw_sel;

    logic [8:0]  rx_mem [RX_FIFO_DEPTH];
    logic [7:0]  tx_mem [TX_FIFO_DEPTH];
    logic [RAW:0] rx_wr, rx_rd, rx_cnt;
    logic [TAW:0] tx_wr, tx_rd, tx_cnt;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        rx_push, rx_pop, tx_push, tx_pop, tx_wr_req;

    uart_state_t rx_state, rx_state_n, tx_state, tx_state_n;
    logic        rx_meta, rx_sync, rx_done, rx_frame_ev, rx_tick, tx_tick, tx_level;
    logic [15:0] rx_baud, rx_div, rx_target, tx_baud, tx_div;
    logic [2:0]  rx_bit, tx_bit;
    logic [7:0]  rx_data, tx_shift;
    logic        rx_perr, rx_fpar_en, rx_fpar_odd, tx_fpar_en, tx_fpar_odd, tx_stop_idx;

    logic        unused_bits;
    assign unused_bits = ^{read_access.araddr[31:6], read_access.araddr[2:0],
                           write_access.awaddr[31:6], write_access.awaddr[2:0],
                           write_access.wdata[63:20], write_access.wstrb};

    // Bus handshakes and address decode
    assign ar_sel                = read_access.araddr[5:3];
    assign aw_sel                = write_access.awaddr[5:3];
    assign read_access.arready   = !rvalid || read_access.rready;
    assign ar_hs                 = read_access.arvalid && (!rvalid || read_access.rready);
    assign aw_hs                 = write_access.awvalid && write_access.wvalid && (!bvalid || write_access.bready);
    assign read_access.rvalid    = rvalid;
    assign read_access.rdata     = rdata;
    assign read_access.rresp     = 2'b00;
    assign write_access.awready  = aw_hs;
    assign write_access.wready   = aw_hs;
    assign write_access.bvalid   = bvalid;
    assign write_access.bresp    = 2'b00;

    // FIFO occupancy; a pop in the same cycle frees the slot for a push
    assign rx_cnt    = rx_wr - rx_rd;
    assign tx_cnt    = tx_wr - tx_rd;
    assign rx_empty  = (rx_cnt == '0);
    assign tx_empty  = (tx_cnt == '0);
    assign rx_full   = (rx_cnt == RX_FULL);
    assign tx_full   = (tx_cnt == TX_FULL);
    assign rx_pop    = ar_hs && (ar_sel == 3'd0) && !rx_empty;
    assign rx_push   = rx_done && (!rx_full || rx_pop);
    assign tx_wr_req = aw_hs && (aw_sel == 3'd2);
    assign tx_push   = tx_wr_req && (!tx_full || tx_pop);
    assign err_set   = {tx_wr_req && tx_full && !tx_pop, rx_done && rx_perr,
                        rx_frame_ev, rx_done && rx_full && !rx_pop};
    assign err_clr   = (aw_hs && aw_sel == 3'd4) ? write_access.wdata[3:0] : 4'd0;

`ifdef UART_IRQ_EN
    logic [2:0] irq_en;
    // IRQ enable register and registered interrupt line
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 3'd0;
            irq    <= 1'b0;
        end else begin
            if (aw_hs && aw_sel == 3'd5) irq_en <= write_access.wdata[2:0];
            irq <= |(irq_en & {|err, tx_empty, !rx_empty});
        end
    end
`endif

    // Read data mux; RX_DATA returns zero when the FIFO is empty
    always_comb begin
        rd_word = '0;
        case (ar_sel)
            3'd0: if (!rx_empty) rd_word = {54'd0, rx_mem[rx_rd[RAW-1:0]][8], 1'b1, rx_mem[rx_rd[RAW-1:0]][7:0]};
            3'd1: rd_word = {29'd0, tx_state != S_IDLE, tx_full, rx_empty, 16'(tx_cnt), 16'(rx_cnt)};
            3'd3: rd_word = {44'd0, ctrl_tx_en, ctrl_rx_en, ctrl_par_odd, ctrl_par_en, ctrl_div};
            3'd4: rd_word = {60'd0, err};
`ifdef UART_IRQ_EN
            3'd5: rd_word = {61'd0, irq_en};
`endif
            default: rd_word = '0;
        endcase
    end

    // Bus responses, CTRL register and sticky ERR flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid       <= 1'b0;
            rdata        <= '0;
            bvalid       <= 1'b0;
            ctrl_div     <= DIV_RST;
            ctrl_par_en  <= 1'b0;
            ctrl_par_odd <= 1'b0;
            ctrl_rx_en   <= 1'b1;
            ctrl_tx_en   <= 1'b1;
            err          <= 4'd0;
        end else begin
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end else if (read_access.rready) begin
                rvalid <= 1'b0;
            end
            if (aw_hs) bvalid <= 1'b1;
            else if (write_access.bready) bvalid <= 1'b0;
            if (aw_hs && aw_sel == 3'd3) begin
                ctrl_div     <= (write_access.wdata[15:0] < 16'd4) ? 16'd4 : write_access.wdata[15:0];
                ctrl_par_en  <= write_access.wdata[16];
                ctrl_par_odd <= write_access.wdata[17];
                ctrl_rx_en   <= write_access.wdata[18];
                ctrl_tx_en   <= write_access.wdata[19];
            end
            err <= (err & ~err_clr) | err_set;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr <= '0;
            rx_rd <= '0;
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + {{RAW{1'b0}}, 1'b1};
            if (rx_pop)  rx_rd <= rx_rd + {{RAW{1'b0}}, 1'b1};
            if (tx_push) tx_wr <= tx_wr + {{TAW{1'b0}}, 1'b1};
            if (tx_pop)  tx_rd <= tx_rd + {{TAW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage; RX entries carry the parity-error flag above the byte
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= {rx_perr, rx_data};
        if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= write_access.wdata[7:0];
    end

    // Two-flop synchroniser for the asynchronous rx line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State registers and registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            tx_state <= S_IDLE;
            tx       <= 1'b1;
        end else begin
            rx_state <= rx_state_n;
            tx_state <= tx_state_n;
            tx       <= tx_level;
        end
    end

    // RX next state; the start bit is re-checked half a bit in, the rest mid-bit
    assign rx_target = (rx_state == S_START) ? ({1'b0, rx_div[15:1]} - 16'd1) : (rx_div - 16'd1);
    assign rx_tick   = (rx_baud == rx_target);
    always_comb begin
        rx_state_n  = rx_state;
        rx_done     = 1'b0;
        rx_frame_ev = 1'b0;
        case (rx_state)
            S_IDLE:   if (ctrl_rx_en && !rx_sync) rx_state_n = S_START;
            S_START:  if (rx_tick) rx_state_n = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_state_n = rx_fpar_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_tick) rx_state_n = S_STOP;
            S_STOP: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_done    = 1'b1;
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_frame_ev = 1'b1;
                        rx_state_n  = S_WAIT;
                    end
                end
            end
            S_WAIT:   if (rx_sync) rx_state_n = S_IDLE;
            default:  rx_state_n = S_IDLE;
        endcase
    end

    // RX datapath; frame settings are captured while idle
    always_ff @(posedge clk) begin
        if (rx_state == S_IDLE) begin
            rx_baud     <= '0;
            rx_bit      <= '0;
            rx_data     <= '0;
            rx_perr     <= 1'b0;
            rx_div      <= ctrl_div;
            rx_fpar_en  <= ctrl_par_en;
            rx_fpar_odd <= ctrl_par_odd;
        end else begin
            rx_baud <= rx_tick ? '0 : rx_baud + 16'd1;
            if (rx_tick && rx_state == S_DATA) begin
                rx_data[rx_bit] <= rx_sync;
                rx_bit          <= rx_bit + 3'd1;
            end
            if (rx_tick && rx_state == S_PARITY) rx_perr <= (rx_sync != (^rx_data ^ rx_fpar_odd));
        end
    end

    // TX next state and line level; the next byte is popped straight out of STOP
    assign tx_tick = (tx_baud == tx_div - 16'd1);
    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_level   = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (ctrl_tx_en && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                tx_level = 1'b0;
                if (tx_tick) tx_state_n = S_DATA;
            end
            S_DATA: begin
                tx_level = tx_shift[tx_bit];
                if (tx_tick && tx_bit == LAST_BIT) tx_state_n = tx_fpar_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_level = ^tx_shift ^ tx_fpar_odd;
                if (tx_tick) tx_state_n = S_STOP;
            end
            S_STOP: begin
                if (tx_tick && tx_stop_idx == STOP_LAST) begin
                    if (ctrl_tx_en && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // TX datapath; a pop loads the byte and freezes this frame's settings
    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_shift    <= tx_mem[tx_rd[TAW-1:0]] & DMASK;
            tx_div      <= ctrl_div;
            tx_fpar_en  <= ctrl_par_en;
            tx_fpar_odd <= ctrl_par_odd;
            tx_baud     <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
        end else begin
            tx_baud <= tx_tick ? '0 : tx_baud + 16'd1;
            if (tx_tick && tx_state == S_DATA) tx_bit <= tx_bit + 3'd1;
            if (tx_tick && tx_state == S_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_axil_fifo.sv
// Directed bench for uart_axil_fifo: register table plus serial-line sequences.
module tb_uart_axil_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
`ifdef UART_IRQ_EN
    logic irq;
`endif
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        string       name;
    } vec_t;

    axil_interface_if bus ();

    uart_axil_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
`ifdef UART_IRQ_EN
        .irq          (irq),
`endif
        .tx           (tx),
        .read_access  (bus),
        .write_access (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [63:0] data);
        int n;
        bus.araddr  = {26'd0, addr};
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.rvalid) begin
            checks++;
            errors++;
            $display("FAIL axi_read_timeout: addr 0x%0h, rvalid never rose", addr);
        end
        data = bus.rdata;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [63:0] data);
        int n;
        bus.awaddr  = {26'd0, addr};
        bus.wdata   = data;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        #1;
        n = 0;
        while (!bus.awready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.bvalid) begin
            checks++;
            errors++;
            $display("FAIL axi_write_timeout: addr 0x%0h, bvalid never rose", addr);
        end
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input bit par,
                              input logic par_val, input logic stop_val);
        hold(1'b0, div);
        for (int i = 0; i < 8; i++) hold(b[i], div);
        if (par) hold(par_val, div);
        hold(stop_val, div);
        rx = 1'b1;
    endtask

    initial begin
        vec_t        vecs [12];
        logic [63:0] d;
        logic [7:0]  txb;
        int          n;

        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0;
        bus.wstrb  = '1; bus.wvalid  = 1'b0; bus.bready = 1'b0;

        vecs[0]  = '{1'b0, 6'h08, 64'h0,         64'h1_0000_0000, "status_reset"};
        vecs[1]  = '{1'b0, 6'h00, 64'h0,         64'h0,           "rxdata_empty"};
        vecs[2]  = '{1'b0, 6'h18, 64'h0,         64'hC_0048,      "ctrl_reset"};
        vecs[3]  = '{1'b0, 6'h20, 64'h0,         64'h0,           "err_reset"};
        vecs[4]  = '{1'b0, 6'h28, 64'h0,         64'h0,           "irq_en_reset"};
        vecs[5]  = '{1'b0, 6'h30, 64'h0,         64'h0,           "unmapped_read"};
        vecs[6]  = '{1'b1, 6'h18, 64'hC_0002,    64'hC_0004,      "ctrl_div_clamp"};
        vecs[7]  = '{1'b1, 6'h18, 64'hF_0123,    64'hF_0123,      "ctrl_readback"};
        vecs[8]  = '{1'b1, 6'h30, 64'hFFFF,      64'h0,           "unmapped_write"};
        vecs[9]  = '{1'b1, 6'h08, 64'hFFFF_FFFF, 64'h1_0000_0000, "status_readonly"};
        vecs[10] = '{1'b1, 6'h20, 64'hF,         64'h0,           "err_w1c_clean"};
        vecs[11] = '{1'b1, 6'h18, 64'hC_0048,    64'hC_0048,      "ctrl_restore"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {63'd0, tx}, 64'd1);
        check("reset_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("reset_bvalid", {63'd0, bus.bvalid}, 64'd0);
        check("reset_rdata", bus.rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata);
            axi_read(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // TX 0x55 at divisor 72
        axi_write(6'h10, 64'h55);
        n = 0;
        while (tx && n < 300) begin @(posedge clk); #1; n++; end
        check("tx_start_seen", {63'd0, tx}, 64'd0);
        n = 0;
        while (!tx && n < 300) begin @(posedge clk); #1; n++; end
        check("tx_start_len", 64'(n), 64'd72);
        txb = 8'h55;
        repeat (36) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_bit%0d", i), {63'd0, tx}, {63'd0, txb[i]});
            repeat (72) @(posedge clk);
            #1;
        end
        check("tx_stop", {63'd0, tx}, 64'd1);
        axi_read(6'h08, d);
        check("status_tx_busy", d, 64'h5_0000_0000);
        repeat (100) @(posedge clk);
        #1;
        axi_read(6'h08, d);
        check("status_tx_done", d, 64'h1_0000_0000);

        // RX 0xA3 at divisor 16
        axi_write(6'h18, 64'hC_0010);
        send_frame(8'hA3, 16, 0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        axi_read(6'h00, d);
        check("rx_a3", d, 64'h1A3);
        axi_read(6'h00, d);
        check("rx_after_pop", d, 64'h0);

        // Odd parity: 0x03 with correct bit, then 0x01 with wrong bit
        axi_write(6'h18, 64'hF_0010);
        send_frame(8'h03, 16, 1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        axi_read(6'h00, d);
        check("rx_parity_good", d, 64'h103);
        axi_read(6'h20, d);
        check("err_parity_none", d, 64'h0);
        send_frame(8'h01, 16, 1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        axi_read(6'h00, d);
        check("rx_parity_bad", d, 64'h301);
        axi_read(6'h20, d);
        check("err_parity_set", d, 64'h4);
        axi_write(6'h20, 64'h4);
        axi_read(6'h20, d);
        check("err_parity_clear", d, 64'h0);
        axi_write(6'h18, 64'hC_0010);

        // RX overflow: 17 frames into a 16-entry FIFO
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 16, 0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        axi_read(6'h08, d);
        check("status_rx_full", d, 64'h10);
        axi_read(6'h20, d);
        check("err_rx_ovf", d, 64'h1);
        for (int i = 0; i < 16; i++) begin
            axi_read(6'h00, d);
            check($sformatf("rx_order%0d", i), d, 64'h100 | 64'(8'h10 + 8'(i)));
        end
        axi_read(6'h00, d);
        check("rx_drained", d, 64'h0);
        axi_write(6'h20, 64'h1);

        // Framing error with rx held low well past the stop bit
        send_frame(8'hC4, 16, 0, 1'b0, 1'b0);
        hold(1'b0, 16 * 12);
        hold(1'b1, 32);
        axi_read(6'h20, d);
        check("err_frame", d, 64'h2);
        axi_read(6'h08, d);
        check("frame_no_byte", d, 64'h1_0000_0000);
        axi_write(6'h20, 64'h1);
        axi_read(6'h20, d);
        check("err_w1c_other_bit", d, 64'h2);
        send_frame(8'h5A, 16, 0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        axi_read(6'h00, d);
        check("rx_after_break", d, 64'h15A);
        axi_read(6'h00, d);
        check("rx_after_break_empty", d, 64'h0);
        axi_write(6'h20, 64'h2);
        axi_read(6'h20, d);
        check("err_frame_clear", d, 64'h0);

        // TX overflow with the transmitter disabled, then drain
        axi_write(6'h18, 64'h4_0010);
        for (int i = 0; i < 17; i++) axi_write(6'h10, 64'h30 + 64'(i));
        axi_read(6'h08, d);
        check("status_tx_full", d, 64'h3_0010_0000);
        axi_read(6'h20, d);
        check("err_tx_ovf", d, 64'h8);
        axi_write(6'h20, 64'h8);
        axi_write(6'h18, 64'hC_0010);
        n = 0;
        d = '0;
        while (d != 64'h1_0000_0000 && n < 100) begin
            repeat (50) @(posedge clk);
            #1;
            axi_read(6'h08, d);
            n++;
        end
        check("tx_drain", d, 64'h1_0000_0000);
        check("tx_idle_line", {63'd0, tx}, 64'd1);
        axi_read(6'h20, d);
        check("err_final", d, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
